// File: rtl/state_sequencer_if.sv
// Bundle of the sequencer's memory-side inputs and its status outputs.
// Handshake: there is no valid/ready pair here. hold is a pure stall input:
// while hold is high nothing in the sequencer advances, and when it drops
// the pending transition occurs on the next rising edge. instr is only
// sampled in the IF state on an edge where hold is low.
interface state_sequencer_if;
  logic [31:0] instr;
  logic        hold;
  logic [3:0]  state;
  logic [2:0]  alu_op;
  logic        retire;
  logic        illegal;
  logic [15:0] instr_count;

  // Memory / stimulus side: supplies instruction data and the wait signal.
  modport master (
    output instr,
    output hold,
    input  state,
    input  alu_op,
    input  retire,
    input  illegal,
    input  instr_count
  );

  // Sequencer side.
  modport slave (
    input  instr,
    input  hold,
    output state,
    output alu_op,
    output retire,
    output illegal,
    output instr_count
  );
endinterface

// File: rtl/state_sequencer.sv
// Multi-cycle MIPS-style control sequencer. Decodes the opcode/funct
// latched in IF and walks the matching state path, producing a registered
// ALU operation, retire/illegal pulses and a retired-instruction counter.
module state_sequencer (
  input  logic              clk,
  input  logic              reset,
  state_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IF        = 4'd0,
    S_ID_1      = 4'd1,
    S_ID_J      = 4'd2,
    S_ID_BNE    = 4'd3,
    S_EX_OP_IMM = 4'd4,
    S_EX_ADDI   = 4'd5,
    S_EX_A_OP_B = 4'd6,
    S_EX_A_ADD0 = 4'd7,
    S_EX_BNE    = 4'd8,
    S_MEM_READ  = 4'd9,
    S_MEM_WRITE = 4'd10,
    S_WB_XORI   = 4'd11,
    S_WB_LW     = 4'd12,
    S_WB_ALU    = 4'd13,
    S_WB_JAL    = 4'd14,
    S_WB_JR     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;

  state_t      state_q, state_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [5:0]  funct_q, funct_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic        retire_q, retire_d;
  logic        illegal_q, illegal_d;
  logic [15:0] instr_count_q, instr_count_d;

  // Only the opcode and funct fields matter to the sequencer.
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instr[25:6];

  // Next-state, decode and pulse generation; nothing moves while hold is high.
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    funct_d       = funct_q;
    alu_op_d      = alu_op_q;
    retire_d      = 1'b0;
    illegal_d     = 1'b0;
    instr_count_d = instr_count_q;

    if (!bus.hold) begin
      case (state_q)
        S_IF: begin
          opcode_d = bus.instr[31:26];
          funct_d  = bus.instr[5:0];
          state_d  = S_ID_1;
        end
        S_ID_1: begin
          alu_op_d = ALU_ADD;
          case (opcode_q)
            OP_RTYPE: begin
              case (funct_q)
                FN_ADD: state_d = S_EX_A_OP_B;
                FN_SUB: begin
                  state_d  = S_EX_A_OP_B;
                  alu_op_d = ALU_SUB;
                end
                FN_SLT: begin
                  state_d  = S_EX_A_OP_B;
                  alu_op_d = ALU_SLT;
                end
                FN_JR:  state_d = S_EX_A_ADD0;
                default: begin
                  state_d   = S_IF;
                  illegal_d = 1'b1;
                end
              endcase
            end
            OP_J:   state_d = S_ID_J;
            OP_JAL: state_d = S_WB_JAL;
            OP_BNE: begin
              state_d  = S_ID_BNE;
              alu_op_d = ALU_SUB;
            end
            OP_XORI: begin
              state_d  = S_EX_OP_IMM;
              alu_op_d = ALU_XOR;
            end
            OP_ADDI, OP_LW, OP_SW: state_d = S_EX_ADDI;
            default: begin
              state_d   = S_IF;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_WB_JAL:    state_d = S_ID_J;
        S_ID_J:      state_d = S_IF;
        S_ID_BNE:    state_d = S_EX_BNE;
        S_EX_BNE:    state_d = S_IF;
        S_EX_OP_IMM: state_d = S_WB_XORI;
        S_WB_XORI:   state_d = S_IF;
        S_EX_ADDI: begin
          case (opcode_q)
            OP_LW:   state_d = S_MEM_READ;
            OP_SW:   state_d = S_MEM_WRITE;
            default: state_d = S_WB_XORI;
          endcase
        end
        S_MEM_READ:  state_d = S_WB_LW;
        S_WB_LW:     state_d = S_IF;
        S_MEM_WRITE: state_d = S_IF;
        S_EX_A_OP_B: state_d = S_WB_ALU;
        S_WB_ALU:    state_d = S_IF;
        S_EX_A_ADD0: state_d = S_WB_JR;
        S_WB_JR:     state_d = S_IF;
        default:     state_d = S_IF;
      endcase

      // Returning to IF from any execution path completes an instruction;
      // the ID_1 -> IF exit is the illegal path and does not retire.
      if (state_d == S_IF && state_q != S_ID_1 && state_q != S_IF) begin
        retire_d      = 1'b1;
        instr_count_d = instr_count_q + 16'd1;
      end
    end
  end

  // State and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IF;
      opcode_q      <= 6'd0;
      funct_q       <= 6'd0;
      alu_op_q      <= 3'd0;
      retire_q      <= 1'b0;
      illegal_q     <= 1'b0;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      funct_q       <= funct_d;
      alu_op_q      <= alu_op_d;
      retire_q      <= retire_d;
      illegal_q     <= illegal_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.retire      = retire_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer: every scenario task starts and ends
// at a falling edge with the sequencer sitting in IF.
module tb_state_sequencer;
  logic        clk;
  logic        reset;
  int          checks;
  int          errors;
  logic [15:0] exp_count;

  state_sequencer_if bus ();

  state_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock generation: 10 ns period, outputs sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    reset     = 1'b0;
    bus.hold  = 1'b0;
    bus.instr = 32'd0;
    #1 reset = 1'b1;
    #2;
    checks++;
    if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", bus.state); end
    checks++;
    if (bus.alu_op !== 3'd0) begin errors++; $display("FAIL reset_alu_op got %0d expected 0", bus.alu_op); end
    checks++;
    if (bus.retire !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got retire=%b illegal=%b expected 0 0", bus.retire, bus.illegal);
    end
    checks++;
    if (bus.instr_count !== 16'd0) begin errors++; $display("FAIL reset_count got %h expected 0000", bus.instr_count); end
    @(negedge clk);
    reset     = 1'b0;
    exp_count = 16'd0;
  endtask

  task automatic test_lw;
    logic [3:0] exp_s [5];
    exp_s = '{4'd1, 4'd5, 4'd9, 4'd12, 4'd0};
    bus.instr = 32'h8C220004;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== exp_s[i]) begin errors++; $display("FAIL lw_state[%0d] got %0d expected %0d", i, bus.state, exp_s[i]); end
      if (i < 4) begin
        checks++;
        if (bus.retire !== 1'b0) begin errors++; $display("FAIL lw_early_retire[%0d] got %b expected 0", i, bus.retire); end
      end
    end
    exp_count++;
    checks++;
    if (bus.retire !== 1'b1) begin errors++; $display("FAIL lw_retire got %b expected 1", bus.retire); end
    checks++;
    if (bus.instr_count !== exp_count) begin errors++; $display("FAIL lw_count got %h expected %h", bus.instr_count, exp_count); end
  endtask

  task automatic test_sub_slt;
    logic [31:0] ins   [2];
    logic [2:0]  alu   [2];
    logic [3:0]  exp_s [4];
    ins   = '{32'h00221822, 32'h0022182A};
    alu   = '{3'd1, 3'd3};
    exp_s = '{4'd1, 4'd6, 4'd13, 4'd0};
    for (int k = 0; k < 2; k++) begin
      bus.instr = ins[k];
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checks++;
        if (bus.state !== exp_s[i]) begin errors++; $display("FAIL rtype%0d_state[%0d] got %0d expected %0d", k, i, bus.state, exp_s[i]); end
        // alu_op changes only on the edge leaving ID_1.
        if (i >= 1) begin
          checks++;
          if (bus.alu_op !== alu[k]) begin errors++; $display("FAIL rtype%0d_alu[%0d] got %0d expected %0d", k, i, bus.alu_op, alu[k]); end
        end
      end
      exp_count++;
      checks++;
      if (bus.retire !== 1'b1 || bus.instr_count !== exp_count) begin
        errors++; $display("FAIL rtype%0d_retire got retire=%b count=%h expected 1 %h", k, bus.retire, bus.instr_count, exp_count);
      end
    end
  endtask

  task automatic test_illegal;
    bus.instr = 32'hFC000000;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd1) begin errors++; $display("FAIL ill_state_id got %0d expected 1", bus.state); end
    checks++;
    if (bus.alu_op !== 3'd3) begin errors++; $display("FAIL ill_alu_before got %0d expected 3", bus.alu_op); end
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd0) begin errors++; $display("FAIL ill_state_if got %0d expected 0", bus.state); end
    checks++;
    if (bus.illegal !== 1'b1 || bus.retire !== 1'b0) begin
      errors++; $display("FAIL ill_pulse got illegal=%b retire=%b expected 1 0", bus.illegal, bus.retire);
    end
    checks++;
    if (bus.instr_count !== exp_count) begin errors++; $display("FAIL ill_count got %h expected %h", bus.instr_count, exp_count); end
    checks++;
    if (bus.alu_op !== 3'd0) begin errors++; $display("FAIL ill_alu got %0d expected 0", bus.alu_op); end
    // Follow with a J to confirm the illegal pulse is single-cycle.
    bus.instr = 32'h08000010;
    @(negedge clk);
    checks++;
    if (bus.illegal !== 1'b0 || bus.state !== 4'd1) begin
      errors++; $display("FAIL ill_once got illegal=%b state=%0d expected 0 1", bus.illegal, bus.state);
    end
    @(negedge clk);
    @(negedge clk);
    exp_count++;
    checks++;
    if (bus.state !== 4'd0 || bus.retire !== 1'b1 || bus.instr_count !== exp_count) begin
      errors++; $display("FAIL ill_next_j got state=%0d retire=%b count=%h expected 0 1 %h", bus.state, bus.retire, bus.instr_count, exp_count);
    end
  endtask

  task automatic test_jal_j;
    logic [3:0] jal_s [4];
    logic [3:0] j_s   [3];
    jal_s = '{4'd1, 4'd14, 4'd2, 4'd0};
    j_s   = '{4'd1, 4'd2, 4'd0};
    bus.instr = 32'h0C000010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== jal_s[i]) begin errors++; $display("FAIL jal_state[%0d] got %0d expected %0d", i, bus.state, jal_s[i]); end
    end
    exp_count++;
    checks++;
    if (bus.retire !== 1'b1 || bus.instr_count !== exp_count) begin
      errors++; $display("FAIL jal_retire got retire=%b count=%h expected 1 %h", bus.retire, bus.instr_count, exp_count);
    end
    bus.instr = 32'h08000010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== j_s[i]) begin errors++; $display("FAIL j_state[%0d] got %0d expected %0d", i, bus.state, j_s[i]); end
    end
    exp_count++;
    checks++;
    if (bus.retire !== 1'b1 || bus.instr_count !== exp_count) begin
      errors++; $display("FAIL j_retire got retire=%b count=%h expected 1 %h", bus.retire, bus.instr_count, exp_count);
    end
  endtask

  task automatic test_other_ops;
    logic [31:0] ins [6];
    logic [2:0]  alu [6];
    logic [3:0]  seq [6][4];
    // XORI, ADDI, BNE, SW, ADD, JR
    ins = '{32'h38000000, 32'h20000000, 32'h14000000, 32'hAC000000, 32'h00000020, 32'h00000008};
    alu = '{3'd2, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
    seq = '{'{4'd1, 4'd4, 4'd11, 4'd0},
            '{4'd1, 4'd5, 4'd11, 4'd0},
            '{4'd1, 4'd3, 4'd8,  4'd0},
            '{4'd1, 4'd5, 4'd10, 4'd0},
            '{4'd1, 4'd6, 4'd13, 4'd0},
            '{4'd1, 4'd7, 4'd15, 4'd0}};
    for (int k = 0; k < 6; k++) begin
      bus.instr = ins[k];
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checks++;
        if (bus.state !== seq[k][i]) begin errors++; $display("FAIL op%0d_state[%0d] got %0d expected %0d", k, i, bus.state, seq[k][i]); end
        if (i >= 1) begin
          checks++;
          if (bus.alu_op !== alu[k]) begin errors++; $display("FAIL op%0d_alu[%0d] got %0d expected %0d", k, i, bus.alu_op, alu[k]); end
        end
      end
      exp_count++;
      checks++;
      if (bus.retire !== 1'b1 || bus.instr_count !== exp_count) begin
        errors++; $display("FAIL op%0d_retire got retire=%b count=%h expected 1 %h", k, bus.retire, bus.instr_count, exp_count);
      end
    end
  endtask

  task automatic test_hold;
    bus.instr = 32'h8C220004;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd9) begin errors++; $display("FAIL hold_reach_mem got %0d expected 9", bus.state); end
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== 4'd9 || bus.retire !== 1'b0 || bus.instr_count !== exp_count) begin
        errors++; $display("FAIL hold_stall[%0d] got state=%0d retire=%b count=%h expected 9 0 %h", i, bus.state, bus.retire, bus.instr_count, exp_count);
      end
    end
    bus.hold = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd12 || bus.retire !== 1'b0) begin
      errors++; $display("FAIL hold_wb got state=%0d retire=%b expected 12 0", bus.state, bus.retire);
    end
    @(negedge clk);
    exp_count++;
    checks++;
    if (bus.state !== 4'd0 || bus.retire !== 1'b1 || bus.instr_count !== exp_count) begin
      errors++; $display("FAIL hold_retire got state=%0d retire=%b count=%h expected 0 1 %h", bus.state, bus.retire, bus.instr_count, exp_count);
    end
    // Hold in the retire cycle: the pulse must drop and IF must not advance.
    bus.hold  = 1'b1;
    bus.instr = 32'h08000010;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd0 || bus.retire !== 1'b0 || bus.instr_count !== exp_count) begin
      errors++; $display("FAIL hold_in_if got state=%0d retire=%b count=%h expected 0 0 %h", bus.state, bus.retire, bus.instr_count, exp_count);
    end
    bus.hold = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd1) begin errors++; $display("FAIL hold_release got %0d expected 1", bus.state); end
    @(negedge clk);
    @(negedge clk);
    exp_count++;
    checks++;
    if (bus.state !== 4'd0 || bus.retire !== 1'b1 || bus.instr_count !== exp_count) begin
      errors++; $display("FAIL hold_after_j got state=%0d retire=%b count=%h expected 0 1 %h", bus.state, bus.retire, bus.instr_count, exp_count);
    end
  endtask

  task automatic test_reset_mid;
    bus.instr = 32'h8C220004;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd9) begin errors++; $display("FAIL rmid_reach_mem got %0d expected 9", bus.state); end
    reset = 1'b1;
    #1;
    exp_count = 16'd0;
    checks++;
    if (bus.state !== 4'd0 || bus.instr_count !== 16'd0 || bus.alu_op !== 3'd0) begin
      errors++; $display("FAIL rmid_async got state=%0d count=%h alu=%0d expected 0 0000 0", bus.state, bus.instr_count, bus.alu_op);
    end
    checks++;
    if (bus.retire !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++; $display("FAIL rmid_pulses got retire=%b illegal=%b expected 0 0", bus.retire, bus.illegal);
    end
    #1 reset = 1'b0;
    bus.instr = 32'h08000010;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd1 || bus.retire !== 1'b0) begin
      errors++; $display("FAIL rmid_first_edge got state=%0d retire=%b expected 1 0", bus.state, bus.retire);
    end
    @(negedge clk);
    @(negedge clk);
    exp_count++;
    checks++;
    if (bus.state !== 4'd0 || bus.retire !== 1'b1 || bus.instr_count !== exp_count) begin
      errors++; $display("FAIL rmid_j got state=%0d retire=%b count=%h expected 0 1 %h", bus.state, bus.retire, bus.instr_count, exp_count);
    end
  endtask

  task automatic test_wrap;
    // Stand-in for 0xFFFF retirements: load the counter while stalled.
    bus.hold = 1'b1;
    force dut.instr_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.instr_count_q;
    @(negedge clk);
    exp_count = 16'hFFFF;
    checks++;
    if (bus.instr_count !== exp_count) begin errors++; $display("FAIL wrap_preload got %h expected ffff", bus.instr_count); end
    bus.hold  = 1'b0;
    bus.instr = 32'h08000010;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    exp_count = exp_count + 16'd1;
    checks++;
    if (bus.state !== 4'd0 || bus.retire !== 1'b1 || bus.illegal !== 1'b0) begin
      errors++; $display("FAIL wrap_retire got state=%0d retire=%b illegal=%b expected 0 1 0", bus.state, bus.retire, bus.illegal);
    end
    checks++;
    if (bus.instr_count !== 16'h0000) begin errors++; $display("FAIL wrap_count got %h expected 0000", bus.instr_count); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_count = 16'd0;
    test_reset();
    test_lw();
    test_sub_slt();
    test_illegal();
    test_jal_j();
    test_other_ops();
    test_hold();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset; the clock port SHALL be named clk and the reset port SHALL be named reset.
REQ-002 clk  input  1  rising-edge clock shared with the control fsm.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 instr  input  32  memory read data; this is the instruction word while state==IF.
REQ-005 hold  input  1  memory wait; while 1, all registers keep their values.
REQ-006 state  output  4  registered current state; drives the control fsm nextstate input.
REQ-007 alu_op  output  3  registered ALU operation: 0=ADD, 1=SUB, 2=XOR, 3=SLT.
REQ-008 retire  output  1  one-cycle pulse; high in the first IF cycle after an instruction completes.
REQ-009 illegal  output  1  one-cycle pulse; high in the IF cycle after an undecodable instruction.
REQ-010 instr_count  output  16  count of retired instructions.

Function
REQ-011 State encoding SHALL be: IF=0, ID_1=1, ID_J=2, ID_BNE=3, EX_OP_IMM=4, EX_ADDI=5, EX_A_OP_B=6, EX_A_ADD0=7, EX_BNE=8, MEM_READ=9, MEM_WRITE=10, WB_XORI=11, WB_LW=12, WB_ALU=13, WB_JAL=14, WB_JR=15.
REQ-012 Leaving IF (hold=0), the block SHALL latch opcode=instr[31:26] and funct=instr[5:0] into internal registers; the next state SHALL be ID_1.
REQ-013 From ID_1, the next state SHALL be selected by the latched opcode/funct:
- J(0x02) -> ID_J
- JAL(0x03) -> WB_JAL
- BNE(0x05) -> ID_BNE
- XORI(0x0E) -> EX_OP_IMM
- ADDI(0x08), LW(0x23), SW(0x2B) -> EX_ADDI
- opcode 0x00 with funct ADD(0x20), SUB(0x22) or SLT(0x2A) -> EX_A_OP_B
- opcode 0x00 with funct JR(0x08) -> EX_A_ADD0
- anything else -> IF, with illegal asserted
REQ-014 Remaining transitions SHALL be:
- WB_JAL->ID_J
- ID_J->IF
- ID_BNE->EX_BNE->IF
- EX_OP_IMM->WB_XORI->IF
- EX_ADDI->WB_XORI for ADDI, ->MEM_READ for LW, ->MEM_WRITE for SW
- MEM_READ->WB_LW->IF
- MEM_WRITE->IF
- EX_A_OP_B->WB_ALU->IF
- EX_A_ADD0->WB_JR->IF
REQ-015 alu_op SHALL update on the edge leaving ID_1 as follows, and SHALL otherwise hold its value:
- XORI -> 2
- BNE and SUB -> 1
- SLT -> 3
- all others -> 0
REQ-016 retire SHALL be 1 for exactly one cycle after every transition into IF from a non-ID_1 state; at that same edge, instr_count SHALL increment by 1.
REQ-017 instr_count SHALL wrap from 0xFFFF to 0x0000 without any other effect.
REQ-018 An illegal instruction SHALL NOT assert retire and SHALL NOT increment instr_count; illegal and retire SHALL never be high in the same cycle.
REQ-019 While hold=1:
- state, opcode, funct, alu_op and instr_count SHALL be held
- retire and illegal SHALL be 0 from the next cycle
REQ-020 When hold deasserts, the pending transition SHALL occur on the next edge.
REQ-021 Instruction latency in clocks, hold=0, measured from IF to the next IF:
- J: 3
- JAL, BNE, XORI, ADDI, SW, R-type, JR: 4
- LW: 5

Reset
REQ-022 Asserting reset SHALL immediately, without a clock edge, force:
- state=IF
- opcode=0, funct=0
- alu_op=0
- retire=0, illegal=0
- instr_count=0
REQ-023 Reset SHALL take priority over hold and over any transition in progress; an instruction aborted mid-sequence SHALL NOT retire.
REQ-024 After reset deasserts, the first rising edge with hold=0 SHALL latch instr and move to ID_1.

Verification
REQ-025 Bench SHALL cover: LW instr=0x8C220004, hold=0 -> state sequence 0,1,5,9,12,0; retire=1 in the final IF cycle; instr_count 0->1.
REQ-026 Bench SHALL cover: R-type SUB instr=0x00221822 -> states 0,1,6,13,0; alu_op=1 from EX_A_OP_B onward. Then SLT instr=0x0022182A -> alu_op=3.
REQ-027 Bench SHALL cover: JAL instr=0x0C000010 -> states 0,1,14,2,0. Then J instr=0x08000010 -> states 0,1,2,0 (3 cycles).
REQ-028 Bench SHALL cover: illegal instr=0xFC000000 -> states 0,1,0; illegal pulses once; retire=0; instr_count unchanged.
REQ-029 Bench SHALL cover: hold=1 for 3 cycles during MEM_READ of an LW -> state stays 9 for 4 cycles total, then proceeds 12,0 with exactly one retire.
REQ-030 Bench SHALL cover: reset asserted between clock edges while state=9 -> state=0 before the next edge; instr_count=0. Separately, preload 0xFFFF retirements -> the next retire wraps instr_count to 0x0000.
